// File: rtl/skew_feed_pkg.sv
// skew_feed_pkg: constants and types used by the skew feed sequencer.
// The same LANES/DRAIN_CYC defaults are used when the skew shifter is
// instantiated, so the sequencer and the shifter agree on group size.
package skew_feed_pkg;

    localparam int ADDR_W_DEF    = 8;
    localparam int GRP_W_DEF     = 8;
    localparam int LANES_DEF     = 4;
    localparam int DRAIN_CYC_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } feed_state_t;

    // Saturating 16-bit increment used by the optional performance counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/feed_addr_gen.sv
// feed_addr_gen: holds the latched base address and group count, walks the
// word position (in-group lane index plus group index) and produces the
// current read address and the last-word flag. The address wraps modulo
// 2^ADDR_W.
module feed_addr_gen
    import skew_feed_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int GRP_W  = GRP_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [GRP_W-1:0]  num_grp,
    input  logic              advance,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [LANE_W-1:0] grp_idx,
    output logic              last_word
);

    logic [ADDR_W-1:0] addr_q;
    logic [LANE_W-1:0] lane_q;
    logic [GRP_W-1:0]  grp_q;
    logic [GRP_W-1:0]  ngrp_q;

    // Load the command on accept, then step one word per issued read.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            lane_q <= '0;
            grp_q  <= '0;
            ngrp_q <= '0;
        end else if (load) begin
            addr_q <= base_addr;
            lane_q <= '0;
            grp_q  <= '0;
            ngrp_q <= num_grp;
        end else if (advance) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (lane_q == LANE_W'(LANES - 1)) begin
                lane_q <= '0;
                grp_q  <= grp_q + GRP_W'(1);
            end else begin
                lane_q <= lane_q + LANE_W'(1);
            end
        end
    end

    assign rd_addr   = addr_q;
    assign grp_idx   = lane_q;
    assign last_word = (lane_q == LANE_W'(LANES - 1)) && (grp_q == ngrp_q - GRP_W'(1));

endmodule

// File: rtl/skew_feed_ctrl.sv
// skew_feed_ctrl: sequencer for the systolic-array skew shifter. Issues one
// buffer read per cycle in whole LANES-word groups, delays the read strobe
// into the shifter valid and array enable, and holds the array enabled for
// the skew drain.
// Optional feature macro: SKEW_FEED_PERF_EN adds stall_cycles/busy_cycles.
module skew_feed_ctrl
    import skew_feed_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int GRP_W     = GRP_W_DEF,
    parameter int LANES     = LANES_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [GRP_W-1:0]  num_grp,
    input  logic              sa_stall,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    output logic              shift_valid,
    output logic              sa_en,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef SKEW_FEED_PERF_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       busy_cycles
`endif
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int F_W    = $clog2(DRAIN_CYC + 3);

    feed_state_t       state_q;
    feed_state_t       state_d;
    logic [F_W-1:0]    flush_q;
    logic              err_q;
    logic              sv_q;
    logic              sa_q;
    logic              accept;
    logic              rd_en;
    logic              advance;
    logic              stall_now;
    logic [ADDR_W-1:0] rd_addr;
    logic [LANE_W-1:0] grp_idx;
    logic              last_word;

    feed_addr_gen #(
        .ADDR_W (ADDR_W),
        .GRP_W  (GRP_W),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .base_addr (base_addr),
        .num_grp   (num_grp),
        .advance   (advance),
        .rd_addr   (rd_addr),
        .grp_idx   (grp_idx),
        .last_word (last_word)
    );

    // Next-state and read issue; stalls only take effect at a group start
    // so the shifter lane pointer never restarts mid-group.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        rd_en     = 1'b0;
        advance   = 1'b0;
        stall_now = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    accept  = 1'b1;
                    state_d = (num_grp == '0) ? ST_DONE : ST_FEED;
                end
            end
            ST_FEED: begin
                stall_now = (grp_idx == '0) && sa_stall;
                if (!stall_now) begin
                    rd_en   = 1'b1;
                    advance = 1'b1;
                    if (last_word) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_q == F_W'(DRAIN_CYC + 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register, drain counter, zero-length flag and the two delay stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            flush_q <= '0;
            err_q   <= 1'b0;
            sv_q    <= 1'b0;
            sa_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= (state_q == ST_FLUSH) ? flush_q + F_W'(1) : '0;
            if (accept) begin
                err_q <= (num_grp == '0);
            end
            sv_q <= rd_en;
            sa_q <= sv_q;
        end
    end

`ifdef SKEW_FEED_PERF_EN
    // Saturating activity counters, restarted by each accepted command.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            stall_cycles <= '0;
            busy_cycles  <= '0;
        end else begin
            if (state_q != ST_IDLE) begin
                busy_cycles <= sat_inc16(busy_cycles);
            end
            if (stall_now) begin
                stall_cycles <= sat_inc16(stall_cycles);
            end
        end
    end
`endif

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign buf_rd_en   = rd_en;
    assign buf_rd_addr = rd_en ? rd_addr : '0;
    assign shift_valid = sv_q;
    assign sa_en       = sa_q || ((state_q == ST_FLUSH) && (flush_q >= F_W'(2)));
    assign done        = (state_q == ST_DONE);
    assign err         = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_skew_feed_ctrl.sv
// tb_skew_feed_ctrl: directed bench for skew_feed_ctrl. Each run drives one
// command plus a per-cycle sa_stall pattern and compares every cycle's
// control outputs against hand-derived cycle masks.
module tb_skew_feed_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [7:0]  base_addr;
    logic [7:0]  num_grp;
    logic        sa_stall;
    logic        buf_rd_en;
    logic [7:0]  buf_rd_addr;
    logic        shift_valid;
    logic        sa_en;
    logic        busy;
    logic        done;
    logic        err;
`ifdef SKEW_FEED_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] busy_cycles;
`endif

    int checks = 0;
    int errors = 0;

    skew_feed_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .base_addr   (base_addr),
        .num_grp     (num_grp),
        .sa_stall    (sa_stall),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .shift_valid (shift_valid),
        .sa_en       (sa_en),
        .busy        (busy),
        .done        (done),
        .err         (err)
`ifdef SKEW_FEED_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .busy_cycles (busy_cycles)
`endif
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one command at cycle 0 and checks cycles 0..ncyc-1.
    // Control vector order: {start_ready, buf_rd_en, shift_valid, sa_en, busy, done, err}.
    task automatic applyStimulus(input string name, input logic [7:0] base, input logic [7:0] ngrp,
                                 input logic [31:0] stall_mask, input int ncyc,
                                 input logic [31:0] exp_rd, input logic [31:0] exp_sv,
                                 input logic [31:0] exp_sa, input logic [31:0] exp_busy,
                                 input logic [31:0] exp_done, input logic [31:0] exp_err,
                                 input logic [63:0] exp_addrs);
        int idx;
        logic [6:0] exp_vec;
        logic [6:0] got_vec;
        idx         = 0;
        start_valid = 1'b1;
        base_addr   = base;
        num_grp     = ngrp;
        sa_stall    = stall_mask[0];
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            exp_vec = {!exp_busy[c], exp_rd[c], exp_sv[c], exp_sa[c], exp_busy[c], exp_done[c], exp_err[c]};
            got_vec = {start_ready, buf_rd_en, shift_valid, sa_en, busy, done, err};
            checkOutput($sformatf("%s ctl c%0d", name, c), 32'(got_vec), 32'(exp_vec));
            if (exp_rd[c] && idx < 8) begin
                checkOutput($sformatf("%s addr c%0d", name, c), 32'(buf_rd_addr), 32'(exp_addrs[8*idx +: 8]));
                idx++;
            end
            @(posedge clk);
            #1;
            start_valid = 1'b0;
            sa_stall    = stall_mask[c+1];
        end
    endtask

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        base_addr   = '0;
        num_grp     = '0;
        sa_stall    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ctl", 32'({start_ready, buf_rd_en, shift_valid, sa_en, busy, done, err}), 32'h40);
        checkOutput("reset addr", 32'(buf_rd_addr), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // One group, no stall.
        applyStimulus("one_grp", 8'h10, 8'd1, 32'h0, 12,
                      32'h1E, 32'h3C, 32'h3F8, 32'h7FE, 32'h400, 32'h0, 64'h13121110);

        // Two groups, boundary stall at cycle 5 delays the second group by one.
        applyStimulus("bnd_stall", 8'h10, 8'd2, 32'h20, 17,
                      32'h3DE, 32'h7BC, 32'h7F78, 32'hFFFE, 32'h8000, 32'h0, 64'h1716151413121110);

        // Stall mid-group (cycles 2-4) and during flush (cycle 6) is ignored.
        applyStimulus("mid_stall", 8'h10, 8'd1, 32'h5C, 12,
                      32'h1E, 32'h3C, 32'h3F8, 32'h7FE, 32'h400, 32'h0, 64'h13121110);

        // Zero-length command: done and err at cycle 1, back to idle at cycle 2.
        applyStimulus("zero_len", 8'h55, 8'd0, 32'h0, 3,
                      32'h0, 32'h0, 32'h0, 32'h2, 32'h2, 32'h2, 64'h0);

        // Address wrap across 0xFF.
        applyStimulus("wrap", 8'hFE, 8'd1, 32'h0, 12,
                      32'h1E, 32'h3C, 32'h3F8, 32'h7FE, 32'h400, 32'h0, 64'h0100FFFE);

        // Reset during FEED at cycle 3, then a fresh command at cycle 4.
        start_valid = 1'b1;
        base_addr   = 8'h30;
        num_grp     = 8'd2;
        @(negedge clk);
        checkOutput("rst_mid c0 ready", 32'(start_ready), 32'h1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        for (int c = 1; c < 4; c++) begin
            if (c == 3) rst = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("rst_mid rd c%0d", c), 32'({buf_rd_en, buf_rd_addr}), 32'({1'b1, 8'(8'h30 + c - 1)}));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        applyStimulus("after_rst", 8'h20, 8'd1, 32'h0, 12,
                      32'h1E, 32'h3C, 32'h3F8, 32'h7FE, 32'h400, 32'h0, 64'h23222120);

        // Two boundary stall cycles at the start of a single group.
        applyStimulus("perf", 8'h40, 8'd1, 32'h6, 14,
                      32'h78, 32'hF0, 32'hFE0, 32'h1FFE, 32'h1000, 32'h0, 64'h43424140);
`ifdef SKEW_FEED_PERF_EN
        @(negedge clk);
        checkOutput("perf stall_cycles", 32'(stall_cycles), 32'd2);
        checkOutput("perf busy_cycles", 32'(busy_cycles), 32'd12);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
